mem_port_arbiter: RTL and testbench

//  Shares the single 32-bit memory port between instruction fetch (requester 0) and

---
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one memory port between instruction fetch (requester 0) and load/store
//   (requester 1). Drives the select line of the 2:1 address mux, registers the winning
//   address and write enable, runs the request/ack handshake with memory, and aborts an
//   access that never receives an ack.
//
//   Build option: define ROUND_ROBIN_EN for alternating priority on ties. Without it
//   load/store always wins a tie.
//
// Parameters
//   AW       address width
//   TIMEOUT  cycles in a serve state without mem_ack before abort (0 disables)
//   TCW      watchdog counter width, 2**TCW must exceed TIMEOUT
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   req0, addr0      fetch request (level) and address
//   req1, addr1, we1 load/store request (level), address, write flag
//   mem_ack          memory completes the current access (1-cycle pulse)
//   sel              mux select, 0 = fetch, 1 = load/store
//   mem_req          access in progress toward memory
//   mem_addr, mem_we registered address / write enable of the current access
//   gnt0, gnt1       1-cycle pulse: request accepted, address captured
//   done0, done1     1-cycle pulse: access finished (ack or timeout)
//   err              1-cycle pulse alongside donex when the watchdog fired
module mem_port_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned TCW     = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic          we1,
  input  logic          mem_ack,
  output logic          sel,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic          err
);

  typedef enum logic [1:0] {StIdle, StServe0, StServe1} state_e;

  state_e         state_q;
  logic [TCW-1:0] wd_q;
  logic           win1;
  logic           any_req;
  logic           wd_limit;

`ifdef ROUND_ROBIN_EN
  // 1: load/store wins the next tie; always favours the requester not granted last.
  logic prio_q;
  assign win1 = req1 & (~req0 | prio_q);
`else
  assign win1 = req1;
`endif

  assign any_req  = req0 | req1;
  assign wd_limit = (TIMEOUT != 0) && (wd_q == TCW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      wd_q     <= '0;
      sel      <= 1'b0;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_we   <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err      <= 1'b0;
`ifdef ROUND_ROBIN_EN
      prio_q   <= 1'b1;
`endif
    end else begin
      gnt0  <= 1'b0;
      gnt1  <= 1'b0;
      done0 <= 1'b0;
      done1 <= 1'b0;
      err   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // mem_ack here is stray and deliberately ignored; sel keeps its last value.
          if (any_req) begin
            state_q  <= win1 ? StServe1 : StServe0;
            sel      <= win1;
            mem_req  <= 1'b1;
            mem_addr <= win1 ? addr1 : addr0;
            mem_we   <= win1 & we1;
            gnt0     <= ~win1;
            gnt1     <= win1;
            wd_q     <= '0;
`ifdef ROUND_ROBIN_EN
            prio_q   <= ~win1;
`endif
          end
        end
        StServe0, StServe1: begin
          // An ack arriving on the limit cycle takes precedence over the timeout.
          if (mem_ack || wd_limit) begin
            state_q <= StIdle;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            wd_q    <= '0;
            done0   <= (state_q == StServe0);
            done1   <= (state_q == StServe1);
            err     <= ~mem_ack;
          end else if (TIMEOUT != 0) begin
            wd_q <= wd_q + TCW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, we1, mem_ack;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic          sel, mem_req, mem_we, gnt0, gnt1, done0, done1, err;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic          port;
    logic [AW-1:0] addr;
    logic          we;
    logic          err;
  } exp_t;

  exp_t sb[$];

  mem_port_arbiter #(
    .AW      (AW),
    .TIMEOUT (4),
    .TCW     (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .addr0    (addr0),
    .req1     (req1),
    .addr1    (addr1),
    .we1      (we1),
    .mem_ack  (mem_ack),
    .sel      (sel),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .done0    (done0),
    .done1    (done1),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (gnt0 || gnt1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done0 || done1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int   n;
    logic seen;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({sel, mem_req, mem_we, gnt0, gnt1, done0, done1, err} !== 8'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=%b",
               {sel, mem_req, mem_we, gnt0, gnt1, done0, done1, err}, 8'b0);
    end
    checks++;
    if (mem_addr !== '0) begin
      failures++;
      $display("FAIL reset_addr got=%h exp=%h", mem_addr, 32'h0);
    end
    rst_n = 1'b1;
    tick();
    // Start a store, then reset while it is being served.
    req1  = 1'b1;
    addr1 = 32'h0000_0040;
    we1   = 1'b1;
    wait_gnt(n);
    req1 = 1'b0;
    we1  = 1'b0;
    checks++;
    if (!(n > 0 && gnt1 === 1'b1 && mem_req === 1'b1 && sel === 1'b1)) begin
      failures++;
      $display("FAIL reset_pre_grant got n=%0d gnt1=%b mem_req=%b exp gnt1=1 mem_req=1",
               n, gnt1, mem_req);
    end
    tick();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({sel, mem_req, mem_we, gnt0, gnt1, done0, done1, err} !== 8'b0) begin
      failures++;
      $display("FAIL reset_async_ctrl got=%b exp=%b",
               {sel, mem_req, mem_we, gnt0, gnt1, done0, done1, err}, 8'b0);
    end
    checks++;
    if (mem_addr !== '0) begin
      failures++;
      $display("FAIL reset_async_addr got=%h exp=%h", mem_addr, 32'h0);
    end
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (6) begin
      tick();
      if (done0 || done1 || err || mem_req) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL reset_no_done got activity=%b exp=0", seen);
    end
  endtask

  task automatic test_single_fetch();
    int   n;
    exp_t e;
    req0  = 1'b1;
    addr0 = 32'h0000_0100;
    sb.push_back('{port: 1'b0, addr: 32'h0000_0100, we: 1'b0, err: 1'b0});
    wait_gnt(n);
    req0 = 1'b0;
    e    = sb.pop_front();
    checks++;
    if (n !== 1 || gnt0 !== 1'b1 || sel !== e.port) begin
      failures++;
      $display("FAIL fetch_gnt got n=%0d gnt0=%b sel=%b exp n=1 gnt0=1 sel=%b",
               n, gnt0, sel, e.port);
    end
    checks++;
    if (mem_addr !== e.addr || mem_we !== e.we || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL fetch_addr got addr=%h we=%b req=%b exp addr=%h we=%b req=1",
               mem_addr, mem_we, mem_req, e.addr, e.we);
    end
    tick();
    tick();
    tick();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== e.addr || done0 !== 1'b0) begin
      failures++;
      $display("FAIL fetch_hold got req=%b addr=%h done0=%b exp req=1 addr=%h done0=0",
               mem_req, mem_addr, done0, e.addr);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (done0 !== 1'b1 || done1 !== 1'b0 || err !== e.err || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL fetch_done got done0=%b done1=%b err=%b req=%b exp 1 0 %b 0",
               done0, done1, err, mem_req, e.err);
    end
    tick();
    checks++;
    if (done0 !== 1'b0) begin
      failures++;
      $display("FAIL fetch_done_pulse got done0=%b exp=0", done0);
    end
  endtask

  task automatic test_store();
    int   n;
    exp_t e;
    req1  = 1'b1;
    we1   = 1'b1;
    addr1 = 32'h8000_0004;
    sb.push_back('{port: 1'b1, addr: 32'h8000_0004, we: 1'b1, err: 1'b0});
    wait_gnt(n);
    req1 = 1'b0;
    we1  = 1'b0;
    e    = sb.pop_front();
    checks++;
    if (gnt1 !== 1'b1 || sel !== e.port || mem_addr !== e.addr || mem_we !== e.we) begin
      failures++;
      $display("FAIL store_gnt got gnt1=%b sel=%b addr=%h we=%b exp 1 %b %h %b",
               gnt1, sel, mem_addr, mem_we, e.port, e.addr, e.we);
    end
    tick();
    checks++;
    if (mem_we !== 1'b1) begin
      failures++;
      $display("FAIL store_we_hold got=%b exp=1", mem_we);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (done1 !== 1'b1 || mem_we !== 1'b0 || err !== e.err || sel !== 1'b1) begin
      failures++;
      $display("FAIL store_done got done1=%b we=%b err=%b sel=%b exp 1 0 %b 1",
               done1, mem_we, err, sel, e.err);
    end
  endtask

  task automatic test_tie();
    int   n;
    exp_t e;
    req0  = 1'b1;
    req1  = 1'b1;
    we1   = 1'b0;
    addr0 = 32'h0000_0200;
    addr1 = 32'h0000_0300;
`ifdef ROUND_ROBIN_EN
    sb.push_back('{port: 1'b1, addr: 32'h0000_0300, we: 1'b0, err: 1'b0});
    sb.push_back('{port: 1'b0, addr: 32'h0000_0200, we: 1'b0, err: 1'b0});
    sb.push_back('{port: 1'b1, addr: 32'h0000_0300, we: 1'b0, err: 1'b0});
`else
    sb.push_back('{port: 1'b1, addr: 32'h0000_0300, we: 1'b0, err: 1'b0});
    sb.push_back('{port: 1'b1, addr: 32'h0000_0300, we: 1'b0, err: 1'b0});
    sb.push_back('{port: 1'b1, addr: 32'h0000_0300, we: 1'b0, err: 1'b0});
`endif
    for (int t = 0; t < 3; t++) begin
      wait_gnt(n);
      e = sb.pop_front();
      checks++;
      if (gnt1 !== e.port || gnt0 !== ~e.port || mem_addr !== e.addr) begin
        failures++;
        $display("FAIL tie_gnt%0d got gnt1=%b gnt0=%b addr=%h exp gnt1=%b addr=%h",
                 t, gnt1, gnt0, mem_addr, e.port, e.addr);
      end
      if (t > 0) begin
        checks++;
        if (n !== 1) begin
          failures++;
          $display("FAIL tie_gap%0d got cycles=%0d exp=1", t, n);
        end
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      checks++;
      if ({done1, done0} !== (e.port ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL tie_done%0d got done1,done0=%b%b exp port=%b",
                 t, done1, done0, e.port);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL tie_quiet got gnt0=%b gnt1=%b req=%b exp 0 0 0", gnt0, gnt1, mem_req);
    end
  endtask

  task automatic test_timeout();
    int   n;
    int   d;
    exp_t e;
    req0  = 1'b1;
    addr0 = 32'h0000_0400;
    sb.push_back('{port: 1'b0, addr: 32'h0000_0400, we: 1'b0, err: 1'b1});
    wait_gnt(n);
    req0 = 1'b0;
    e    = sb.pop_front();
    checks++;
    if (gnt0 !== 1'b1 || mem_addr !== e.addr) begin
      failures++;
      $display("FAIL to_gnt got gnt0=%b addr=%h exp 1 %h", gnt0, mem_addr, e.addr);
    end
    wait_done(d);
    checks++;
    if (d !== 4 || done0 !== 1'b1 || err !== e.err || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL to_abort got cycles=%0d done0=%b err=%b req=%b exp 4 1 %b 0",
               d, done0, err, mem_req, e.err);
    end
    tick();
    checks++;
    if (err !== 1'b0 || done0 !== 1'b0) begin
      failures++;
      $display("FAIL to_err_pulse got err=%b done0=%b exp 0 0", err, done0);
    end
    // Ack arriving on the limit cycle completes normally.
    req0 = 1'b1;
    sb.push_back('{port: 1'b0, addr: 32'h0000_0400, we: 1'b0, err: 1'b0});
    wait_gnt(n);
    req0 = 1'b0;
    e    = sb.pop_front();
    tick();
    tick();
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (done0 !== 1'b1 || err !== e.err) begin
      failures++;
      $display("FAIL to_ack_limit got done0=%b err=%b exp 1 %b", done0, err, e.err);
    end
  endtask

  task automatic test_spurious_ack();
    tick();
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    checks++;
    if (done0 !== 1'b0 || done1 !== 1'b0 || err !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL spur_ack got done0=%b done1=%b err=%b req=%b exp 0 0 0 0",
               done0, done1, err, mem_req);
    end
    tick();
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || mem_req !== 1'b0) begin
      failures++;
      $display("FAIL spur_idle got gnt0=%b gnt1=%b req=%b exp 0 0 0", gnt0, gnt1, mem_req);
    end
  endtask

  initial begin
    rst_n   = 1'b1;
    req0    = 1'b0;
    req1    = 1'b0;
    we1     = 1'b0;
    mem_ack = 1'b0;
    addr0   = '0;
    addr1   = '0;
    test_reset();
    test_single_fetch();
    test_store();
    test_tie();
    test_timeout();
    test_spurious_ack();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
